// File: rtl/ysyx_22041211_alu_pkg.sv
// Shared definitions for the ALU front-end: opcode encodings, the opcode
// width and the arbiter/sequencer FSM state encoding.
package ysyx_22041211_alu_pkg;

  localparam int OP_LEN = 4;

  // ALU opcode encodings; anything above ALU_PASS2 makes the ALU return 0.
  localparam logic [OP_LEN-1:0] ALU_ADD   = 4'd0;
  localparam logic [OP_LEN-1:0] ALU_SUB   = 4'd1;
  localparam logic [OP_LEN-1:0] ALU_SLL   = 4'd2;
  localparam logic [OP_LEN-1:0] ALU_SLT   = 4'd3;
  localparam logic [OP_LEN-1:0] ALU_SLTU  = 4'd4;
  localparam logic [OP_LEN-1:0] ALU_XOR   = 4'd5;
  localparam logic [OP_LEN-1:0] ALU_SRL   = 4'd6;
  localparam logic [OP_LEN-1:0] ALU_SRA   = 4'd7;
  localparam logic [OP_LEN-1:0] ALU_OR    = 4'd8;
  localparam logic [OP_LEN-1:0] ALU_AND   = 4'd9;
  localparam logic [OP_LEN-1:0] ALU_PASS2 = 4'd10;

  // Sequencer states: wait for a request, let the ALU settle, hold the result.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/ysyx_22041211_rr_pick.sv
// Two-way grant picker. Purely combinational; the parent owns last_grant.
// With rr_en set, a tie goes to the port that did not win last time
// (last_grant=1 means port 1 won last, so port 0 gets the tie).
// With rr_en clear, port 0 always wins a tie.
module ysyx_22041211_rr_pick (
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       rr_en,
  output logic [1:0] grant
);

  // One-hot grant; a lone valid always wins, ties follow the tie-break rule.
  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = (rr_en && !last_grant) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/ysyx_22041211_alu_arb.sv
// Two-port arbiter/sequencer in front of the shared combinational ALU.
// One packet at a time: IDLE (grant + latch operands) -> EXEC (ALU settles,
// result captured) -> RESP (result held on the owner's response channel).
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high; reqN_ready is only high in IDLE for the granted port, and
// rspN_valid stays high with a stable rsp_result until rspN_ready is seen.
// Build option YSYX_22041211_ALU_ARB_RR_EN: round-robin tie-break using a
// last_grant register; without it port 0 always wins a tie.
// The opcode width comes from ysyx_22041211_alu_pkg::OP_LEN.
module ysyx_22041211_alu_arb
  import ysyx_22041211_alu_pkg::*;
#(
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [DATA_LEN-1:0] req0_src1,
  input  logic [DATA_LEN-1:0] req0_src2,
  input  logic [OP_LEN-1:0]   req0_op,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [DATA_LEN-1:0] req1_src1,
  input  logic [DATA_LEN-1:0] req1_src2,
  input  logic [OP_LEN-1:0]   req1_op,
  output logic                rsp0_valid,
  input  logic                rsp0_ready,
  output logic                rsp1_valid,
  input  logic                rsp1_ready,
  output logic [DATA_LEN-1:0] rsp_result,
  output logic [DATA_LEN-1:0] alu_src1,
  output logic [DATA_LEN-1:0] alu_src2,
  output logic [OP_LEN-1:0]   alu_control,
  input  logic [DATA_LEN-1:0] alu_result,
  output arb_state_e          dbg_state
);

  arb_state_e          state_q;
  logic                owner_q;
  logic [DATA_LEN-1:0] src1_q;
  logic [DATA_LEN-1:0] src2_q;
  logic [OP_LEN-1:0]   op_q;
  logic [DATA_LEN-1:0] result_q;
  logic                rsp0_valid_q;
  logic                rsp1_valid_q;

  logic [1:0]          grant;
  logic                last_grant;
  logic                rr_en;
  logic [DATA_LEN-1:0] src1_d;
  logic [DATA_LEN-1:0] src2_d;
  logic [OP_LEN-1:0]   op_d;
  logic                owner_rsp_ready;

`ifdef YSYX_22041211_ALU_ARB_RR_EN
  logic last_grant_q;

  // Remember which port won the most recent accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else if (state_q == ST_IDLE && (|grant)) begin
      last_grant_q <= grant[1];
    end
  end

  assign last_grant = last_grant_q;
  assign rr_en      = 1'b1;
`else
  assign last_grant = 1'b1;
  assign rr_en      = 1'b0;
`endif

  ysyx_22041211_rr_pick u_pick (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .rr_en      (rr_en),
    .grant      (grant)
  );

  // Ready is combinational from valid, and forced low while reset is held.
  assign req0_ready = (state_q == ST_IDLE) && !rst && grant[0];
  assign req1_ready = (state_q == ST_IDLE) && !rst && grant[1];

  // Operands of whichever port is granted this cycle.
  assign src1_d = grant[1] ? req1_src1 : req0_src1;
  assign src2_d = grant[1] ? req1_src2 : req0_src2;
  assign op_d   = grant[1] ? req1_op   : req0_op;

  assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

  // Sequencer FSM with registered ALU operands, result and response valids.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      src1_q       <= '0;
      src2_q       <= '0;
      op_q         <= ALU_ADD;
      result_q     <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (|grant) begin
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            op_q    <= op_d;
            owner_q <= grant[1];
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          result_q     <= alu_result;
          rsp0_valid_q <= !owner_q;
          rsp1_valid_q <= owner_q;
          state_q      <= ST_RESP;
        end
        ST_RESP: begin
          if (owner_rsp_ready) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign alu_src1    = src1_q;
  assign alu_src2    = src2_q;
  assign alu_control = op_q;
  assign rsp_result  = result_q;
  assign rsp0_valid  = rsp0_valid_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign dbg_state   = state_q;

endmodule
